// File: rtl/ram_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl_if
// Producer/consumer side of the RAM-backed FIFO controller.
//   push_valid / push_data / push_ready : enqueue handshake
//   pop_req / pop_ready                 : dequeue request handshake
//   pop_data / pop_data_valid           : registered read data + 1-cycle pulse
//   count / full / empty                : occupancy status
//   ovf_err / udf_err                   : sticky error flags (RAM_FIFO_ERR_EN)
// Modports: master = producer/consumer side, slave = controller side.
// Optional feature macro: RAM_FIFO_ERR_EN.
// ---------------------------------------------------------------------------
interface ram_fifo_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              push_valid;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              pop_req;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;
    logic              pop_data_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
`ifdef RAM_FIFO_ERR_EN
    logic              ovf_err;
    logic              udf_err;
`endif

    modport master (
        output push_valid, push_data, pop_req,
        input  push_ready, pop_ready, pop_data, pop_data_valid,
        input  count, full, empty
`ifdef RAM_FIFO_ERR_EN
        , input ovf_err, udf_err
`endif
    );

    modport slave (
        input  push_valid, push_data, pop_req,
        output push_ready, pop_ready, pop_data, pop_data_valid,
        output count, full, empty
`ifdef RAM_FIFO_ERR_EN
        , output ovf_err, udf_err
`endif
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
// FIFO controller in front of a 2**ADDR_W x DATA_W level-sensitive RAM.
// Turns push/pop handshakes into one-cycle registered RAM wr/rd strobes,
// tracks read/write pointers and occupancy, and returns read data on a
// registered output with a one-cycle valid pulse. One operation per two
// cycles at most; a pending pop beats a push when the FIFO is non-empty.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   bus (slave)       : push/pop handshakes, pop data, count/full/empty
//   ram_address       : RAM address (registered)
//   ram_data_in       : RAM write data (registered)
//   ram_wr, ram_rd    : RAM strobes (registered, never high together)
//   ram_data_out      : RAM read data
// Optional feature macro: RAM_FIFO_ERR_EN (sticky ovf_err / udf_err on bus).
// ---------------------------------------------------------------------------
module ram_fifo_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_fifo_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_wr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_data_out
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
    logic              ram_wr_q, ram_wr_d;
    logic              ram_rd_q, ram_rd_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_data_valid_q, pop_data_valid_d;

    logic full, empty, idle, push_ready, pop_ready, do_push, do_pop;

    // Status comes from the occupancy counter only, so a full FIFO with
    // equal pointers is never mistaken for an empty one.
    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign idle  = (state_q == ST_IDLE);

    // A pending pop on a non-empty FIFO blocks the push for this cycle.
    assign push_ready = idle & ~full & ~(bus.pop_req & ~empty);
    assign pop_ready  = idle & ~empty;
    assign do_pop     = pop_ready & bus.pop_req;
    assign do_push    = push_ready & bus.push_valid;

    always_comb begin
        state_d          = state_q;
        wptr_d           = wptr_q;
        rptr_d           = rptr_q;
        count_d          = count_q;
        ram_address_d    = ram_address_q;
        ram_data_in_d    = ram_data_in_q;
        ram_wr_d         = 1'b0;
        ram_rd_d         = 1'b0;
        pop_data_d       = pop_data_q;
        pop_data_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (do_pop) begin
                    ram_address_d = rptr_q;
                    ram_rd_d      = 1'b1;
                    state_d       = ST_READ;
                end else if (do_push) begin
                    ram_address_d = wptr_q;
                    ram_data_in_d = bus.push_data;
                    ram_wr_d      = 1'b1;
                    state_d       = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // RAM has seen a full cycle of stable wr/address/data.
                wptr_d  = wptr_q + 1'b1;
                count_d = count_q + 1'b1;
                state_d = ST_IDLE;
            end
            ST_READ: begin
                pop_data_d       = ram_data_out;
                pop_data_valid_d = 1'b1;
                rptr_d           = rptr_q + 1'b1;
                count_d          = count_q - 1'b1;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            wptr_q           <= '0;
            rptr_q           <= '0;
            count_q          <= '0;
            ram_address_q    <= '0;
            ram_data_in_q    <= '0;
            ram_wr_q         <= 1'b0;
            ram_rd_q         <= 1'b0;
            pop_data_q       <= '0;
            pop_data_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            count_q          <= count_d;
            ram_address_q    <= ram_address_d;
            ram_data_in_q    <= ram_data_in_d;
            ram_wr_q         <= ram_wr_d;
            ram_rd_q         <= ram_rd_d;
            pop_data_q       <= pop_data_d;
            pop_data_valid_q <= pop_data_valid_d;
        end
    end

`ifdef RAM_FIFO_ERR_EN
    logic ovf_err_q, udf_err_q;

    // Sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            if (bus.push_valid && full)
                ovf_err_q <= 1'b1;
            if (bus.pop_req && empty && idle)
                udf_err_q <= 1'b1;
        end
    end

    assign bus.ovf_err = ovf_err_q;
    assign bus.udf_err = udf_err_q;
`endif

    assign bus.push_ready     = push_ready;
    assign bus.pop_ready      = pop_ready;
    assign bus.pop_data       = pop_data_q;
    assign bus.pop_data_valid = pop_data_valid_q;
    assign bus.count          = count_q;
    assign bus.full           = full;
    assign bus.empty          = empty;
    assign ram_address        = ram_address_q;
    assign ram_data_in        = ram_data_in_q;
    assign ram_wr             = ram_wr_q;
    assign ram_rd             = ram_rd_q;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_fifo_ctrl
// Directed bench for ram_fifo_ctrl with a behavioural 16x4 RAM attached.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// there as well, away from the active edge.
// Optional feature macro: RAM_FIFO_ERR_EN (adds error-flag comparisons).
// ---------------------------------------------------------------------------
module tb_ram_fifo_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_wr;
    logic              ram_rd;
    logic [DATA_W-1:0] ram_data_out;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks;
    int n_errors;

    ram_fifo_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fif ();

    ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (fif.slave),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_wr       (ram_wr),
        .ram_rd       (ram_rd),
        .ram_data_out (ram_data_out)
    );

    // Level-sensitive RAM model: write while wr is high, read while rd high.
    always @(posedge clk) if (ram_wr) mem[ram_address] <= ram_data_in;
    assign ram_data_out = ram_rd ? mem[ram_address] : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fif.push_valid = 1'b0;
        fif.pop_req    = 1'b0;
        fif.push_data  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_word(input logic [3:0] data, input logic [3:0] exp_addr);
        fif.push_valid = 1'b1;
        fif.push_data  = data;
        #1;
        check("push_ready_idle", fif.push_ready, 1);
        tick();
        fif.push_valid = 1'b0;
        check("push_wr", ram_wr, 1);
        check("push_rd_low", ram_rd, 0);
        check("push_addr", ram_address, exp_addr);
        check("push_din", ram_data_in, data);
        check("push_ready_in_write", fif.push_ready, 0);
        tick();
        check("push_wr_drop", ram_wr, 0);
    endtask

    task automatic pop_word(input logic [3:0] exp_addr, input logic [3:0] exp_data);
        fif.pop_req = 1'b1;
        #1;
        check("pop_ready_idle", fif.pop_ready, 1);
        tick();
        fif.pop_req = 1'b0;
        check("pop_rd", ram_rd, 1);
        check("pop_wr_low", ram_wr, 0);
        check("pop_addr", ram_address, exp_addr);
        check("pop_valid_early", fif.pop_data_valid, 0);
        tick();
        check("pop_rd_drop", ram_rd, 0);
        check("pop_valid", fif.pop_data_valid, 1);
        check("pop_data", fif.pop_data, exp_data);
        tick();
        check("pop_valid_pulse", fif.pop_data_valid, 0);
        check("pop_data_hold", fif.pop_data, exp_data);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        do_reset();

        // Reset state
        check("rst_empty", fif.empty, 1);
        check("rst_full", fif.full, 0);
        check("rst_count", fif.count, 0);
        check("rst_wr", ram_wr, 0);
        check("rst_rd", ram_rd, 0);
        check("rst_valid", fif.pop_data_valid, 0);
        check("rst_addr", ram_address, 0);
        check("rst_pop_data", fif.pop_data, 0);

        // Push 1..3, then pop them back in order
        for (int i = 0; i < 3; i++) push_word(4'(i + 1), 4'(i));
        check("count_3", fif.count, 3);
        for (int i = 0; i < 3; i++) pop_word(4'(i + 3 - 3), 4'(i + 1));
        check("empty_after_pops", fif.empty, 1);

        // Fill from reset pointers
        do_reset();
        for (int i = 0; i < 16; i++) push_word(4'(i + 1), 4'(i));
        check("full_16", fif.full, 1);
        check("count_16", fif.count, 16);
        check("push_ready_full", fif.push_ready, 0);

        // 17th push is ignored
        fif.push_valid = 1'b1;
        fif.push_data  = 4'h7;
        tick();
        fif.push_valid = 1'b0;
        check("ovf_no_wr", ram_wr, 0);
        tick();
        check("ovf_count", fif.count, 16);
`ifdef RAM_FIFO_ERR_EN
        check("ovf_err", fif.ovf_err, 1);
`endif

        // Drain in order; data i+1 mod 16
        for (int i = 0; i < 16; i++) pop_word(4'(i), 4'(i + 1));
        check("empty_after_drain", fif.empty, 1);

        // Pointers wrapped to 0
        push_word(4'hA, 4'h0);
        push_word(4'hB, 4'h1);
        check("wrap_count", fif.count, 2);

        // Simultaneous push and pop with count=2: pop first
        fif.push_valid = 1'b1;
        fif.push_data  = 4'hC;
        fif.pop_req    = 1'b1;
        #1;
        check("both_push_ready", fif.push_ready, 0);
        check("both_pop_ready", fif.pop_ready, 1);
        tick();
        fif.pop_req = 1'b0;
        check("both_rd_first", ram_rd, 1);
        check("both_wr_low", ram_wr, 0);
        check("both_rd_addr", ram_address, 0);
        tick();
        check("both_pop_data", fif.pop_data, 4'hA);
        check("both_pop_valid", fif.pop_data_valid, 1);
        check("both_count_1", fif.count, 1);
        check("both_push_ready_now", fif.push_ready, 1);
        tick();
        fif.push_valid = 1'b0;
        check("both_wr_second", ram_wr, 1);
        check("both_wr_addr", ram_address, 2);
        check("both_wr_data", ram_data_in, 4'hC);
        tick();
        check("both_count_2", fif.count, 2);

        // Reset in the middle of a WRITE
        fif.push_valid = 1'b1;
        fif.push_data  = 4'h5;
        tick();
        fif.push_valid = 1'b0;
        check("mid_wr_high", ram_wr, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wr_drop", ram_wr, 0);
        check("async_count", fif.count, 0);
        check("async_empty", fif.empty, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Pop on empty is refused; push with pop_req on empty is taken
        fif.pop_req = 1'b1;
        #1;
        check("udf_pop_ready", fif.pop_ready, 0);
        fif.push_valid = 1'b1;
        fif.push_data  = 4'h9;
        #1;
        check("empty_push_ready", fif.push_ready, 1);
        tick();
        fif.push_valid = 1'b0;
        fif.pop_req    = 1'b0;
        check("empty_push_wr", ram_wr, 1);
        check("empty_push_no_rd", ram_rd, 0);
        check("empty_push_addr", ram_address, 0);
`ifdef RAM_FIFO_ERR_EN
        check("udf_err", fif.udf_err, 1);
        check("ovf_err_cleared", fif.ovf_err, 0);
`endif
        tick();
        check("empty_push_count", fif.count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller sitting directly upstream of the 16x4 level-sensitive RAM (ports address/data_in/wr/rd/data_out).
- Converts a valid/ready push/pop interface into single-cycle RAM write and read strobes.
- Tracks write/read pointers and occupancy; returns read data on a registered output with a one-cycle valid pulse.
- Serves producers and consumers that need ordered buffering through the existing RAM without driving addresses themselves.

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W (16).
- DATA_W, 4, data word width; must match the RAM word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push_valid  input  1  producer has a word on push_data.
- push_data  input  DATA_W  word to enqueue.
- push_ready  output  1  controller accepts a push this cycle.
- pop_req  input  1  consumer requests one word.
- pop_ready  output  1  controller accepts a pop request this cycle.
- pop_data  output  DATA_W  dequeued word, registered.
- pop_data_valid  output  1  one-cycle pulse; pop_data is valid.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- ram_address  output  ADDR_W  to RAM address.
- ram_data_in  output  DATA_W  to RAM data_in.
- ram_wr  output  1  to RAM wr, registered.
- ram_rd  output  1  to RAM rd, registered.
- ram_data_out  input  DATA_W  from RAM data_out.

Behaviour:
- Single clock clk; reset asynchronous active-low on rst_n.
- Reset values: state=IDLE, wptr=rptr=0, count=0, empty=1, full=0, ram_wr=ram_rd=0, ram_address=0, ram_data_in=0, pop_data=0, pop_data_valid=0.
- RAM contents are not cleared; after reset the FIFO is logically empty.
- FSM states: IDLE, WRITE, READ.
- push_ready = (state==IDLE) & ~full & ~(pop_req & ~empty).
- pop_ready = (state==IDLE) & ~empty.
- Simultaneous push and pop in IDLE with FIFO non-empty: pop wins; the push stalls with push_ready=0.
- Push with FIFO empty and pop_req=1: push is taken; pop_ready=0.
- Push accept (edge N):
  - Capture push_data into ram_data_in; ram_address<=wptr; ram_wr<=1; state->WRITE.
  - During cycle N..N+1, ram_wr=1 with stable address and data.
  - At edge N+1: ram_wr<=0, wptr<=wptr+1 (mod DEPTH), count+1, state->IDLE.
- Pop accept (edge N):
  - ram_address<=rptr; ram_rd<=1; state->READ.
  - At edge N+1: pop_data<=ram_data_out, pop_data_valid<=1, ram_rd<=0, rptr<=rptr+1 (mod DEPTH), count-1, state->IDLE.
  - pop_data_valid is high for exactly cycle N+1..N+2; pop_data holds its value until the next pop.
- ram_wr and ram_rd are never high together; each is high for exactly one cycle per operation.
- Throughput: at most one operation per 2 cycles.
- Pointers wrap 15->0; full/empty are derived from count, never from pointer equality.
- count updates only at the end of WRITE or READ; full/empty are combinational from count.
- push_valid while full, or pop_req while empty: ignored, no state change.
- Reset asserted mid-WRITE or mid-READ: outputs drop immediately; the in-flight operation is lost; count=0.

Optional Feature:
- Macro: RAM_FIFO_ERR_EN.
- Defined:
  - Adds outputs ovf_err (1) and udf_err (1), both reset to 0.
  - ovf_err sets sticky on push_valid=1 while full=1.
  - udf_err sets sticky on pop_req=1 while empty=1 and state==IDLE.
  - Both clear only on reset.
- Undefined: neither port exists; illegal requests are silently ignored.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, ram_wr=ram_rd=0, pop_data_valid=0.
- Push 4'h1..4'h3 one at a time -> ram_wr pulses at addresses 0,1,2 with data 1,2,3; count=3; push_ready low during each WRITE cycle.
- Pop 3 times after pushing 1,2,3 -> ram_rd at addresses 0,1,2; pop_data=1,2,3, each with a one-cycle pop_data_valid; empty=1 at end.
- Push 16 words (data = i+1 mod 16) -> full=1, count=16, push_ready=0.
  - A 17th push leaves count=16 (ovf_err=1 with RAM_FIFO_ERR_EN).
  - Pop all 16 -> data returned in order; wrap check: push 2 more -> addresses 0 and 1.
- push_valid and pop_req high together with count=2 -> pop served first (ram_rd), then push (ram_wr); count returns to 2.
- Assert rst_n=0 during a WRITE cycle -> ram_wr falls without waiting for the clock; count=0, empty=1; a pop_req afterwards gives pop_ready=0 (udf_err=1 with macro).
